// File: rtl/sample_pwm_out_if.sv
// sample_pwm_out_if: bus between the amplitude multiplier / control side and
// the PWM output stage.
//   mult         multiplier product (2*M bits), valid while update is high
//   update       product strobe; a rising edge marks a new product
//   overrun_clr  synchronous clear of the sticky overrun flag
//   pwm_out      registered PWM pin
//   sample_out   duty value currently being played
//   period_start one-cycle pulse in the first cycle of each PWM period
//   overrun      sticky flag: a pending sample was overwritten before play
// Modports: master drives the product and control side; slave is the PWM stage.
interface sample_pwm_out_if #(
  parameter int unsigned M     = 12,
  parameter int unsigned OUT_W = 8
);
  logic [2*M-1:0]   mult;
  logic             update;
  logic             overrun_clr;
  logic             pwm_out;
  logic [OUT_W-1:0] sample_out;
  logic             period_start;
  logic             overrun;

  modport master (
    output mult, update, overrun_clr,
    input  pwm_out, sample_out, period_start, overrun
  );

  modport slave (
    input  mult, update, overrun_clr,
    output pwm_out, sample_out, period_start, overrun
  );
endinterface

// File: rtl/sample_pwm_out.sv
// sample_pwm_out: output stage of the DDS voice path.
// Captures each multiplier product on the rising edge of update, quantizes it
// to OUT_W bits, holds it in a pending buffer and swaps it into the playing
// duty register only at PWM period boundaries, so every period is glitch-free.
// The PWM period is 2^OUT_W-1 clocks, so duty all-ones means constantly high.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high
//   bus  sample_pwm_out_if.slave (mult, update, overrun_clr in;
//        pwm_out, sample_out, period_start, overrun out)
// Build option: define SAMPLE_PWM_NOISE_SHAPE_EN to replace round-half-up with
// first-order error feedback (residual carried into the next capture).
module sample_pwm_out #(
  parameter int unsigned M     = 12,
  parameter int unsigned OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  sample_pwm_out_if.slave     bus
);

  localparam int unsigned PW    = 2 * M;          // product width
  localparam int unsigned ERR_W = PW - OUT_W;     // discarded fraction width
  localparam int unsigned QW    = OUT_W + 1;      // quantizer sum width
  localparam logic [OUT_W-1:0] CNT_LAST = OUT_W'((2 ** OUT_W) - 2);

  // State
  logic [OUT_W-1:0] cnt;
  logic [OUT_W-1:0] pending;
  logic             pending_valid;
  logic             update_d;
  logic [OUT_W-1:0] sample_q;
  logic             pwm_q;
  logic             period_start_q;
  logic             overrun_q;

  // Next-state values
  logic [OUT_W-1:0] cnt_nxt;
  logic [OUT_W-1:0] pending_nxt;
  logic             pending_valid_nxt;
  logic [OUT_W-1:0] sample_nxt;
  logic             pwm_nxt;
  logic             period_start_nxt;
  logic             overrun_nxt;

  // Decode
  logic             capture_c;
  logic             wrap_c;
  logic             load_c;
  logic [OUT_W-1:0] q_c;

`ifdef SAMPLE_PWM_NOISE_SHAPE_EN
  localparam int unsigned SW = PW + 1;

  logic [ERR_W-1:0] err;
  logic [ERR_W-1:0] err_nxt;
  logic [SW-1:0]    s_c;
  logic             sat_c;

  // Error-feedback quantizer: add the previous residual, truncate, saturate.
  always_comb begin
    s_c     = SW'(bus.mult) + SW'(err);
    sat_c   = s_c[PW];
    q_c     = sat_c ? {OUT_W{1'b1}} : s_c[PW-1 -: OUT_W];
    err_nxt = err;
    if (capture_c) begin
      err_nxt = sat_c ? {ERR_W{1'b1}} : s_c[ERR_W-1:0];
    end
  end

  // Residual register; only advances on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      err <= err_nxt;
    end
  end
`else
  logic [QW-1:0] q_sum_c;

  // Round-half-up on the top OUT_W bits; a carry out saturates instead of wrapping.
  always_comb begin
    q_sum_c = QW'(bus.mult[PW-1 -: OUT_W]) + QW'(bus.mult[ERR_W-1]);
    q_c     = q_sum_c[OUT_W] ? {OUT_W{1'b1}} : q_sum_c[OUT_W-1:0];
  end
`endif

  // Next-state logic for capture, double buffer, period counter and outputs.
  always_comb begin
    capture_c         = bus.update & ~update_d;
    wrap_c            = (cnt == CNT_LAST);
    // A load empties the pending slot on this edge, so a capture on the same
    // edge refills it rather than overwriting an unplayed sample.
    load_c            = wrap_c & pending_valid;

    cnt_nxt           = wrap_c ? '0 : cnt + OUT_W'(1);
    sample_nxt        = sample_q;
    pending_nxt       = pending;
    pending_valid_nxt = pending_valid;
    overrun_nxt       = overrun_q;

    if (load_c) begin
      sample_nxt        = pending;
      pending_valid_nxt = 1'b0;
    end

    if (capture_c) begin
      pending_nxt       = q_c;
      pending_valid_nxt = 1'b1;
      if (pending_valid && !load_c) begin
        overrun_nxt = 1'b1;
      end
    end

    // Clear wins over a simultaneous set.
    if (bus.overrun_clr) begin
      overrun_nxt = 1'b0;
    end

    period_start_nxt  = (cnt_nxt == '0);
    pwm_nxt           = (cnt < sample_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      pending        <= '0;
      pending_valid  <= 1'b0;
      update_d       <= 1'b0;
      sample_q       <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      pending        <= pending_nxt;
      pending_valid  <= pending_valid_nxt;
      update_d       <= bus.update;
      sample_q       <= sample_nxt;
      pwm_q          <= pwm_nxt;
      period_start_q <= period_start_nxt;
      overrun_q      <= overrun_nxt;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.sample_out   = sample_q;
  assign bus.period_start = period_start_q;
  assign bus.overrun      = overrun_q;

endmodule
